instr_fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle CPU. Owns the program counter, issues in-order word reads to instruction memory over a request/grant and response handshake, and buffers fetched words in a 2-entry queue. Presents {pc, instruction, opcode} to the decode/control stage with a valid/ready handshake. Supports PC redirection with discard of in-flight responses.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/instr_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants, also used by the control unit.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        IDLE,
        RUN
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a flush that discards all entries in one cycle.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != CNT_W'(DEPTH)) | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC ownership, credit-limited memory requests,
// response tagging, 2-entry instruction queue and redirect with response drop.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [6:0]        op_o,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = $bits(fetch_entry_t);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  drop;
    logic [CNT_W-1:0]  instr_count;
    logic [CNT_W-1:0]  tag_count;
    logic [ADDR_W-1:0] tag_pc;
    logic [ENTRY_W-1:0] head_bits;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;
    logic              credit;
    logic              grant;
    logic              resp_ok;
    logic              resp_drop;
    logic              resp_keep;
    logic              pop;
    logic              unused_lsb;

    // Requests in flight plus queued entries may never exceed the queue depth.
    assign credit    = ({1'b0, outstanding} + {1'b0, instr_count}) < (CNT_W + 1)'(DEPTH);
    assign grant     = imem_req_o & imem_gnt_i;
    assign resp_ok   = imem_rvalid_i & (outstanding != '0);
    assign resp_drop = resp_ok & (drop != '0);
    assign resp_keep = resp_ok & (drop == '0) & (tag_count != '0) & ~redirect_i;
    assign pop       = instr_valid_o & instr_ready_i & ~redirect_i;

    assign imem_addr_o   = fetch_pc;
    assign instr_valid_o = (instr_count != '0);
    assign push_entry    = '{pc: PC_W'(tag_pc), instr: imem_rdata_i};
    assign head_entry    = fetch_entry_t'(head_bits);
    assign instr_o       = head_entry.instr;
    assign pc_o          = ADDR_W'(head_entry.pc);
    assign op_o          = head_entry.instr[6:0];
    assign unused_lsb    = ^redirect_pc_i[1:0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        imem_req_o = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                imem_req_o = ~redirect_i & credit;
                if (!start_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A redirect re-arms drop with every response still owed, excluding one returning now.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(resp_ok);
            if (redirect_i) begin
                fetch_pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
                drop     <= outstanding - CNT_W'(resp_ok);
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                end
                if (resp_drop) begin
                    drop <= drop - CNT_W'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .flush     (redirect_i),
        .push      (grant),
        .pop       (resp_keep),
        .push_data (fetch_pc),
        .head      (tag_pc),
        .count     (tag_count)
    );

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .flush     (redirect_i),
        .push      (resp_keep),
        .pop       (pop),
        .push_data (push_entry),
        .head      (head_bits),
        .count     (instr_count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory model in the driver, expected
// fetch results queued per test and popped by an independent monitor.
module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    logic        clk;
    logic        rst_n_i;
    logic        start_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [6:0]  op_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    exp_t        exp_q[$];
    rsp_t        resp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          lat = 1;
    logic        gnt_en = 1'b1;
    logic        auto_ready = 1'b0;
    logic        last_req = 1'b0;
    logic [31:0] last_addr = '0;

    instr_fetch_unit dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .start_i       (start_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .op_o          (op_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0020_81B3;
        return {a[24:0], 7'b0010011};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    // One clock cycle, entered and left 1 time unit after a rising edge.
    task automatic tick();
        if (auto_ready) instr_ready_i = (exp_q.size() != 0);
        if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(resp_q[0].addr);
            void'(resp_q.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end
        #1;
        imem_gnt_i = gnt_en;
        last_req   = imem_req_o;
        last_addr  = imem_addr_o;
        if (imem_req_o && gnt_en && rst_n_i) begin
            rsp_t r;
            r.addr = imem_addr_o;
            r.due  = cyc + lat;
            resp_q.push_back(r);
            n_acc++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'b0, imem_req_o},    32'h0);
        check({tag, "_addr"},  imem_addr_o,            32'h0);
        check({tag, "_valid"}, {31'b0, instr_valid_o}, 32'h0);
        check({tag, "_instr"}, instr_o,                32'h0);
        check({tag, "_pc"},    pc_o,                   32'h0);
        check({tag, "_op"},    {25'b0, op_o},          32'h0);
    endtask

    task automatic do_reset();
        rst_n_i       = 1'b0;
        start_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        auto_ready    = 1'b0;
        gnt_en        = 1'b1;
        lat           = 1;
        resp_q.delete();
        exp_q.delete();
        #1;
        check_reset_outputs("reset");
        tick();
        tick();
        rst_n_i = 1'b1;
        n_acc   = 0;
    endtask

    task automatic wait_acc(input string name, input int target, input int budget);
        int k = 0;
        while (n_acc < target && k < budget) begin
            tick();
            k++;
        end
        check({name, "_grants"}, n_acc, target);
    endtask

    task automatic wait_exp(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL %s_drain: %0d fetches still owed after %0d cycles, required 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    // Monitor: every accepted head is matched against the next expected fetch.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n_i && !redirect_i && instr_valid_o && instr_ready_i) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_pop: got pc %h, required no fetch", pc_o);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", pc_o, e.pc);
                    check("pop_instr", instr_o, e.instr);
                    check("pop_op", {25'b0, op_o}, {25'b0, e.instr[6:0]});
                end
            end
        end
    end

    initial begin
        rst_n_i       = 1'b0;
        start_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        @(posedge clk);
        #1;

        $display("[TB] streaming fetch");
        do_reset();
        push_exp(32'h0, 32'h0020_81B3);
        push_exp(32'h4, 32'h0000_0213);
        push_exp(32'h8, 32'h0000_0413);
        push_exp(32'hC, 32'h0000_0613);
        auto_ready = 1'b1;
        start_i    = 1'b1;
        wait_exp("stream", 40);

        $display("[TB] decode stall");
        do_reset();
        start_i = 1'b1;
        repeat (7) tick();
        check("stall_grants", n_acc, 2);
        check("stall_no_req", {31'b0, last_req}, 32'h0);
        check("stall_valid", {31'b0, instr_valid_o}, 32'h1);
        check("stall_head_pc", pc_o, 32'h0);
        push_exp(32'h0, 32'h0020_81B3);
        push_exp(32'h4, 32'h0000_0213);
        auto_ready = 1'b1;
        wait_exp("stall", 20);
        wait_acc("stall_resume", 3, 10);

        $display("[TB] grant withheld");
        do_reset();
        push_exp(32'h0, 32'h0020_81B3);
        push_exp(32'h4, 32'h0000_0213);
        push_exp(32'h8, 32'h0000_0413);
        push_exp(32'hC, 32'h0000_0613);
        auto_ready = 1'b1;
        start_i    = 1'b1;
        wait_acc("gnt_pre", 2, 20);
        gnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gnt_hold_addr", last_addr, 32'h8);
        end
        gnt_en = 1'b1;
        wait_acc("gnt_post", 3, 10);
        tick();
        check("gnt_next_addr", last_addr, 32'hC);
        wait_exp("gnt", 40);

        $display("[TB] redirect with responses in flight");
        do_reset();
        lat     = 3;
        start_i = 1'b1;
        wait_acc("redir_pre", 2, 20);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        tick();
        redirect_i = 1'b0;
        check("redir_valid_low", {31'b0, instr_valid_o}, 32'h0);
        push_exp(32'h100, 32'h0000_8013);
        push_exp(32'h104, 32'h0000_8213);
        auto_ready = 1'b1;
        wait_exp("redir", 40);

        $display("[TB] address wrap");
        do_reset();
        start_i = 1'b1;
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        check("wrap_req_blocked", {31'b0, last_req}, 32'h0);
        redirect_i = 1'b0;
        push_exp(32'hFFFF_FFFC, 32'hFFFF_FE13);
        push_exp(32'h0, 32'h0020_81B3);
        auto_ready = 1'b1;
        wait_acc("wrap_first", 1, 10);
        tick();
        check("wrap_addr", last_addr, 32'h0);
        wait_exp("wrap", 40);

        $display("[TB] reset mid-stream");
        do_reset();
        start_i = 1'b1;
        wait_acc("mid_pre", 2, 20);
        check("mid_head_instr", instr_o, 32'h0020_81B3);
        rst_n_i = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        start_i = 1'b0;
        rst_n_i = 1'b1;
        tick();
        tick();
        check("late_rvalid_ignored", {31'b0, instr_valid_o}, 32'h0);
        push_exp(32'h0, 32'h0020_81B3);
        push_exp(32'h4, 32'h0000_0213);
        auto_ready = 1'b1;
        start_i    = 1'b1;
        wait_exp("restart", 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
